// File: rtl/i2s_dsp_pkg.sv
// Shared definitions for the DSP-mode I2S RX and TX channels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2s_dsp_pkg;

    localparam int I2S_WORD_W = 32;
    localparam int I2S_CNT_W  = 5;
    localparam int I2S_OFFS_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WS = 2'd1,
        ST_OFFSET  = 2'd2,
        ST_RUN     = 2'd3
    } dsp_state_e;

endpackage

// File: rtl/i2s_rx_dsp_outbuf.sv
// Two-slot ordered output buffer: ch0 word presented first, then ch1.
// Latency: a loaded word is visible in the cycle after the push edge.
// Backpressure: a push while any slot stays pending is dropped whole and flagged.
module i2s_rx_dsp_outbuf
    import i2s_dsp_pkg::*;
(
    input  logic                  sck_i,
    input  logic                  rstn_i,
    input  logic                  flush,
    input  logic                  push_vld,
    input  logic                  push_2ch,
    input  logic [I2S_WORD_W-1:0] push_ch0_dat,
    input  logic [I2S_WORD_W-1:0] push_ch1_dat,
    output logic                  push_ovf,
    output logic [I2S_WORD_W-1:0] out_dat,
    output logic                  out_vld,
    input  logic                  out_rdy
);

    logic [1:0]            slot_vld_q;
    logic [I2S_WORD_W-1:0] slot0_dat_q;
    logic [I2S_WORD_W-1:0] slot1_dat_q;
    logic                  pop0;
    logic                  pop1;
    logic                  pending;
    logic                  load;

    assign out_vld = |slot_vld_q;
    assign out_dat = slot_vld_q[0] ? slot0_dat_q :
                     slot_vld_q[1] ? slot1_dat_q : '0;

    // A slot leaving on this very edge does not count as pending, so a
    // completion coinciding with the last handshake is still accepted.
    assign pop0     = out_rdy & slot_vld_q[0];
    assign pop1     = out_rdy & ~slot_vld_q[0] & slot_vld_q[1];
    assign pending  = (slot_vld_q[0] & ~pop0) | (slot_vld_q[1] & ~pop1);
    assign push_ovf = push_vld & pending;
    assign load     = push_vld & ~pending;

    // Slot storage: drain on handshake, refill on accepted push, drop all on flush.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot_vld_q  <= '0;
            slot0_dat_q <= '0;
            slot1_dat_q <= '0;
        end else if (flush) begin
            slot_vld_q  <= '0;
            slot0_dat_q <= '0;
            slot1_dat_q <= '0;
        end else begin
            if (pop0) slot_vld_q[0] <= 1'b0;
            if (pop1) slot_vld_q[1] <= 1'b0;
            if (load) begin
                slot_vld_q[0] <= 1'b1;
                slot0_dat_q   <= push_ch0_dat;
                slot_vld_q[1] <= push_2ch;
                if (push_2ch) slot1_dat_q <= push_ch1_dat;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_dsp_channel.sv
// DSP-mode I2S receiver: frame-sync, bit offset, 1-32 bit word assembly on 1 or 2 lines.
// Latency: word valid in the cycle after its last-bit edge; ch1 one cycle after ch0 handshake.
// Backpressure: valid/ready to the RX FIFO; a word completing while data is pending is dropped with fifo_err_o.
module i2s_rx_dsp_channel
    import i2s_dsp_pkg::*;
(
    input  logic                  sck_i,
    input  logic                  rstn_i,
    input  logic                  i2s_ch0_i,
    input  logic                  i2s_ch1_i,
    input  logic                  i2s_ws_i,
    output logic [I2S_WORD_W-1:0] fifo_data_o,
    output logic                  fifo_data_valid_o,
    input  logic                  fifo_data_ready_i,
    output logic                  fifo_err_o,
    input  logic                  cfg_en_i,
    input  logic                  cfg_2ch_i,
    input  logic [I2S_CNT_W-1:0]  cfg_num_bits_i,
    input  logic                  cfg_lsb_first_i,
    input  logic [I2S_OFFS_W-1:0] cfg_master_dsp_offset_i
);

    dsp_state_e            state_q, state_nxt, frame_state;
    logic [I2S_OFFS_W-1:0] offs_q, offs_nxt;
    logic [I2S_CNT_W-1:0]  bit_q, bit_nxt;
    logic [I2S_WORD_W-1:0] sr0_q, sr0_nxt, sr1_q, sr1_nxt;
    logic [I2S_WORD_W-1:0] asm0, asm1;
    logic                  err_q;
    logic                  word_done, resync_err, flush, push_ovf;
    logic                  bit_last, offs_last, ch1_bit;

    assign ch1_bit     = i2s_ch1_i & cfg_2ch_i;
    assign bit_last    = (bit_q == cfg_num_bits_i);
    assign offs_last   = ((offs_q + I2S_OFFS_W'(1)) == cfg_master_dsp_offset_i);
    assign frame_state = (cfg_master_dsp_offset_i == '0) ? ST_RUN : ST_OFFSET;
    assign fifo_err_o  = err_q;

    // Word contents including the bit on the current edge; registers start at 0 so upper bits stay clear.
    always_comb begin
        asm0 = sr0_q;
        asm1 = sr1_q;
        if (cfg_lsb_first_i) begin
            asm0[bit_q] = i2s_ch0_i;
            asm1[bit_q] = ch1_bit;
        end else begin
            asm0 = {sr0_q[I2S_WORD_W-2:0], i2s_ch0_i};
            asm1 = {sr1_q[I2S_WORD_W-2:0], ch1_bit};
        end
    end

    // Frame FSM: next state, counters and shift registers.
    always_comb begin
        state_nxt  = state_q;
        offs_nxt   = offs_q;
        bit_nxt    = bit_q;
        sr0_nxt    = sr0_q;
        sr1_nxt    = sr1_q;
        word_done  = 1'b0;
        resync_err = 1'b0;
        flush      = 1'b0;
        if (!cfg_en_i) begin
            state_nxt = ST_IDLE;
            offs_nxt  = '0;
            bit_nxt   = '0;
            sr0_nxt   = '0;
            sr1_nxt   = '0;
            flush     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_nxt = ST_WAIT_WS;
                ST_WAIT_WS: begin
                    if (i2s_ws_i) begin
                        state_nxt = frame_state;
                        offs_nxt  = '0;
                        bit_nxt   = '0;
                        sr0_nxt   = '0;
                        sr1_nxt   = '0;
                    end
                end
                ST_OFFSET: begin
                    if (i2s_ws_i) begin
                        offs_nxt = '0;
                    end else if (offs_last) begin
                        state_nxt = ST_RUN;
                        bit_nxt   = '0;
                        sr0_nxt   = '0;
                        sr1_nxt   = '0;
                    end else begin
                        offs_nxt = offs_q + I2S_OFFS_W'(1);
                    end
                end
                ST_RUN: begin
                    if (i2s_ws_i && !bit_last) begin
                        // Sync arrived mid-word: drop the partial word and treat this edge as a new frame.
                        resync_err = 1'b1;
                        state_nxt  = frame_state;
                        offs_nxt   = '0;
                        bit_nxt    = '0;
                        sr0_nxt    = '0;
                        sr1_nxt    = '0;
                    end else if (bit_last) begin
                        word_done = 1'b1;
                        offs_nxt  = '0;
                        bit_nxt   = '0;
                        sr0_nxt   = '0;
                        sr1_nxt   = '0;
                        state_nxt = i2s_ws_i ? frame_state : ST_WAIT_WS;
                    end else begin
                        sr0_nxt = asm0;
                        sr1_nxt = asm1;
                        bit_nxt = bit_q + I2S_CNT_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, counter, shift-register and error-pulse registers.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            offs_q  <= '0;
            bit_q   <= '0;
            sr0_q   <= '0;
            sr1_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            offs_q  <= offs_nxt;
            bit_q   <= bit_nxt;
            sr0_q   <= sr0_nxt;
            sr1_q   <= sr1_nxt;
            err_q   <= resync_err | push_ovf;
        end
    end

    i2s_rx_dsp_outbuf u_outbuf (
        .sck_i        (sck_i),
        .rstn_i       (rstn_i),
        .flush        (flush),
        .push_vld     (word_done),
        .push_2ch     (cfg_2ch_i),
        .push_ch0_dat (asm0),
        .push_ch1_dat (asm1),
        .push_ovf     (push_ovf),
        .out_dat      (fifo_data_o),
        .out_vld      (fifo_data_valid_o),
        .out_rdy      (fifo_data_ready_i)
    );

endmodule
